segment_scanner: RTL and testbench

- Consumes the parallel `display_segments` bus produced by the calculator top, `8*NumDigits` bits wide.
- Time-multiplexes that bus onto a physical common-anode 7-segment display: one shared segment bus plus one anode enable per digit.
- Takes a snapshot of the input once per frame, so a frame never shows a mix of old and new values.
- Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/segment_scanner.sv | 96 +++++++++
 tb/tb_segment_scanner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/segment_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with per-frame snapshot and inter-digit blanking.
// Optional PWM dimming is enabled by defining SEGMENT_SCANNER_DIM_EN (adds brightness_i).
module segment_scanner #(
  parameter int unsigned NumDigits   = 8,
  parameter int unsigned DigitCycles = 100000,
  parameter int unsigned BlankCycles = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [8*NumDigits-1:0] display_segments_i,
`ifdef SEGMENT_SCANNER_DIM_EN
  input  logic [3:0]             brightness_i,
`endif
  output logic [NumDigits-1:0]   anodes_o,
  output logic [7:0]             segments_o,
  output logic                   frame_o
);

  localparam int unsigned PhaseW = (DigitCycles > 1) ? $clog2(DigitCycles) : 1;
  localparam int unsigned DigitW = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(DigitCycles - 1);
  localparam logic [DigitW-1:0] DigitLast = DigitW'(NumDigits - 1);
  localparam logic [PhaseW-1:0] BlankEnd  = PhaseW'(BlankCycles);

  logic [PhaseW-1:0]         phase_q;
  logic [DigitW-1:0]         digit_q;
  logic [NumDigits-1:0][7:0] snap_q;
  logic                      frame_start;
  logic                      lit;
  logic [NumDigits-1:0]      anodes_d;
  logic [7:0]                segments_d;

  assign frame_start = (phase_q == '0) && (digit_q == '0);

  // Free-running slot phase and digit index
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      digit_q <= '0;
    end else if (phase_q == PhaseLast) begin
      phase_q <= '0;
      digit_q <= (digit_q == DigitLast) ? '0 : digit_q + DigitW'(1);
    end else begin
      phase_q <= phase_q + PhaseW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_q <= '0;
    end else if (frame_start) begin
      snap_q <= display_segments_i;
    end
  end

`ifdef SEGMENT_SCANNER_DIM_EN
  logic [3:0] bright_q;
  logic [3:0] pwm;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bright_q <= 4'hF;
    end else if (frame_start) begin
      bright_q <= brightness_i;
    end
  end

  // Only meaningful during DRIVE, where phase_q >= BlankCycles
  assign pwm = 4'(phase_q - BlankEnd);
  assign lit = (bright_q == 4'hF) || (pwm < bright_q);
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    anodes_d   = '1;
    segments_d = 8'hFF;
    if ((phase_q >= BlankEnd) && lit) begin
      anodes_d   = ~(NumDigits'(1) << digit_q);
      segments_d = ~snap_q[digit_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      anodes_o   <= '1;
      segments_o <= 8'hFF;
      frame_o    <= 1'b0;
    end else begin
      anodes_o   <= anodes_d;
      segments_o <= segments_d;
      frame_o    <= frame_start;
    end
  end

endmodule

// File: tb/tb_segment_scanner.sv
// Directed + randomized bench for segment_scanner against a slot/phase reference model.
// Covers dimming when SEGMENT_SCANNER_DIM_EN is defined.
module tb_segment_scanner;

  localparam int ND    = 4;
  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * DC;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [31:0]   seg_in = 32'h3F06_5B4F;
  logic [3:0]    bright_in = 4'hF;
  logic [ND-1:0] anodes_o;
  logic [7:0]    segments_o;
  logic          frame_o;

  int n_chk = 0;
  int n_fail = 0;
  int t = 0;
  int frames = 0;
  int act_cnt = 0;
  int last_an = -1;
  int off_run = 0;
  logic [31:0] m_snap = '0;
  logic [3:0]  m_bright = 4'hF;

  always #5 clk_i = ~clk_i;

  segment_scanner #(.NumDigits(ND), .DigitCycles(DC), .BlankCycles(BC)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .display_segments_i(seg_in),
`ifdef SEGMENT_SCANNER_DIM_EN
    .brightness_i(bright_in),
`endif
    .anodes_o(anodes_o),
    .segments_o(segments_o),
    .frame_o(frame_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at t=%0d: observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // One clock: model the snapshot, advance, then compare against slot/phase rules
  task automatic step();
    int ph, dg, pwm, active;
    logic on;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic [7:0] byte_v;
    if (t % FRAME == 0) begin
      m_snap = seg_in;
`ifdef SEGMENT_SCANNER_DIM_EN
      m_bright = bright_in;
`endif
    end
    @(posedge clk_i);
    #1;
    ph = t % DC;
    dg = (t / DC) % ND;
    pwm = (ph - BC) % 16;
    on = (ph >= BC) && ((m_bright == 4'hF) || (pwm < int'(m_bright)));
    exp_an = 4'hF;
    exp_seg = 8'hFF;
    if (on) begin
      byte_v = 8'((m_snap >> (8 * dg)) & 32'hFF);
      exp_an = ~(4'(1) << dg);
      exp_seg = ~byte_v;
    end
    chk("anodes", 32'(anodes_o), 32'(exp_an));
    chk("segments", 32'(segments_o), 32'(exp_seg));
    chk("frame", 32'(frame_o), 32'(t % FRAME == 0));
    chk("anode_onehot", 32'($countones(~anodes_o) <= 1), 32'd1);
    active = -1;
    for (int i = 0; i < ND; i++) if (anodes_o[i] === 1'b0) active = i;
    if (active >= 0) begin
      act_cnt++;
      if (last_an >= 0 && active != last_an) chk("blank_gap", 32'(off_run >= BC), 32'd1);
      last_an = active;
      off_run = 0;
    end else begin
      off_run++;
    end
    if (frame_o === 1'b1) frames++;
    t++;
  endtask

  task automatic run_until(input int target);
    while (t <= target) step();
  endtask

  task automatic release_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    t = 0;
    last_an = -1;
    off_run = 0;
  endtask

  initial begin
    int base;
    // Reset held low
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_anodes", 32'(anodes_o), 32'hF);
    chk("rst_segments", 32'(segments_o), 32'hFF);
    chk("rst_frame", 32'(frame_o), 32'h0);

    // Basic scan
    release_reset();
    run_until(2);
    chk("scan_d0_an", 32'(anodes_o), 32'b1110);
    chk("scan_d0_seg", 32'(segments_o), 32'hB0);
    run_until(10);
    chk("scan_d1_an", 32'(anodes_o), 32'b1101);
    chk("scan_d1_seg", 32'(segments_o), 32'hA4);
    run_until(18);
    chk("scan_d2_an", 32'(anodes_o), 32'b1011);
    chk("scan_d2_seg", 32'(segments_o), 32'hF9);
    run_until(26);
    chk("scan_d3_an", 32'(anodes_o), 32'b0111);
    chk("scan_d3_seg", 32'(segments_o), 32'hC0);
    run_until(63);
    chk("frame_count", 32'(frames), 32'd2);

    // Snapshot coherence: change input at the start of digit 2
    run_until(79);
    seg_in = 32'hFFFF_FFFF;
    run_until(84);
    chk("coh_d2_old", 32'(segments_o), 32'hF9);
    run_until(92);
    chk("coh_d3_old", 32'(segments_o), 32'hC0);
    run_until(98);
    chk("coh_d0_new", 32'(segments_o), 32'h00);

    // Random value held, then changing every cycle
    seg_in = $urandom;
    repeat (1000) step();
    for (int i = 0; i < 200; i++) begin
      seg_in = $urandom;
      step();
    end

    // DP and bit order
    seg_in = 32'h0000_0080;
    base = ((t + FRAME - 1) / FRAME) * FRAME;
    run_until(base + 3);
    chk("dp_d0_an", 32'(anodes_o), 32'b1110);
    chk("dp_d0_seg", 32'(segments_o), 32'h7F);
    run_until(base + 11);
    chk("dp_d1_an", 32'(anodes_o), 32'b1101);
    chk("dp_d1_seg", 32'(segments_o), 32'hFF);

`ifdef SEGMENT_SCANNER_DIM_EN
    seg_in = 32'h3F06_5B4F;
    bright_in = 4'd0;
    base = ((t + FRAME - 1) / FRAME) * FRAME;
    run_until(base);
    act_cnt = 0;
    run_until(base + FRAME - 1);
    chk("dim0_dark", 32'(act_cnt), 32'd0);
    bright_in = 4'd3;
    base = base + FRAME;
    run_until(base);
    act_cnt = 0;
    run_until(base + DC - 1);
    chk("dim3_on", 32'(act_cnt), 32'd3);
    bright_in = 4'd15;
    base = base + FRAME;
    run_until(base);
    act_cnt = 0;
    run_until(base + DC - 1);
    chk("dim15_on", 32'(act_cnt), 32'(DC - BC));
`endif

    // Reset mid-DRIVE, checked before any clock edge
    seg_in = 32'hA5A5_A5A5;
    while (t % DC != 4) step();
    chk("pre_rst_driving", 32'(anodes_o != 4'hF), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_anodes", 32'(anodes_o), 32'hF);
    chk("async_rst_segments", 32'(segments_o), 32'hFF);
    chk("async_rst_frame", 32'(frame_o), 32'h0);
    seg_in = 32'h1234_5678;
    m_bright = 4'hF;
`ifdef SEGMENT_SCANNER_DIM_EN
    bright_in = 4'hF;
`endif
    release_reset();
    run_until(2);
    chk("restart_d0_an", 32'(anodes_o), 32'b1110);
    chk("restart_d0_seg", 32'(segments_o), 32'h87);
    run_until(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
